// File: rtl/bus_demux_2_pkg.sv
// Shared types and defaults for the bus_demux_2 request router.
package bus_demux_2_pkg;

  localparam int          DATA_W_DEF     = 32;
  localparam logic [31:0] SPLIT_ADDR_DEF = 32'hFFFF_0000;
  localparam int          TIMEOUT_DEF    = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Word accesses only: any nonzero low address bit is an alignment error.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/bus_demux_2_if.sv
// Upstream request/response bus plus the two downstream request ports.
interface bus_demux_2_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              a_valid,     b_valid;
  logic              a_ready,     b_ready;
  logic              a_we,        b_we;
  logic [DATA_W-1:0] a_addr,      b_addr;
  logic [DATA_W-1:0] a_wdata,     b_wdata;
  logic              a_rsp_valid, b_rsp_valid;
  logic [DATA_W-1:0] a_rdata,     b_rdata;

  // Router side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output a_valid, a_we, a_addr, a_wdata,
    input  a_ready, a_rsp_valid, a_rdata,
    output b_valid, b_we, b_addr, b_wdata,
    input  b_ready, b_rsp_valid, b_rdata
  );

  // Core plus responders side.
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  a_valid, a_we, a_addr, a_wdata,
    output a_ready, a_rsp_valid, a_rdata,
    input  b_valid, b_we, b_addr, b_wdata,
    output b_ready, b_rsp_valid, b_rdata
  );
endinterface

// File: rtl/bus_demux_2_mux_2.sv
// 2:1 read-data selector: i_sel=0 picks i_a (data memory), 1 picks i_b (MMIO).
module mux_2 #(
  parameter int W = 32
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);

  // Plain select; no state.
  always_comb begin
    if (i_sel) begin
      o_y = i_b;
    end else begin
      o_y = i_a;
    end
  end

endmodule

// File: rtl/bus_demux_2.sv
// Single-outstanding request router: data memory on port A, MMIO on port B.
module bus_demux_2
  import bus_demux_2_pkg::*;
#(
  parameter int                DATA_W     = DATA_W_DEF,
  parameter logic [DATA_W-1:0] SPLIT_ADDR = SPLIT_ADDR_DEF,
  parameter int                TIMEOUT    = TIMEOUT_DEF
) (
  input logic          clk,
  input logic          rst_n,
  bus_demux_2_if.slave bus
);

  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  state_e            r_state;
  state_e            w_next_state;
  logic              r_we;
  logic              r_sel;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_cnt;
  logic              r_a_valid;
  logic              r_b_valid;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic              w_req_sel;
  logic              w_next_sel;
  logic              w_tgt_ready;
  logic              w_tgt_rsp;
  logic              w_timeout;
  logic [DATA_W-1:0] w_mux_rdata;

  // Only the selected target's handshakes matter; the other port is ignored.
  assign w_req_sel   = (bus.req_addr >= SPLIT_ADDR);
  assign w_next_sel  = (r_state == ST_IDLE && bus.req_valid) ? w_req_sel : r_sel;
  assign w_tgt_ready = r_sel ? bus.b_ready     : bus.a_ready;
  assign w_tgt_rsp   = r_sel ? bus.b_rsp_valid : bus.a_rsp_valid;
  assign w_timeout   = (r_cnt == TO_LAST);

  mux_2 #(.W(DATA_W)) u_rdata_mux (
    .i_sel (r_sel),
    .i_a   (bus.a_rdata),
    .i_b   (bus.b_rdata),
    .o_y   (w_mux_rdata)
  );

  // Next-state decode; a completion in WAIT takes priority over the timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (is_misaligned(bus.req_addr[1:0])) begin
            w_next_state = ST_RESP;
          end else begin
            w_next_state = ST_ISSUE;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (w_timeout) begin
          w_next_state = ST_RESP;
        end else if (w_tgt_ready) begin
          w_next_state = ST_WAIT;
        end else begin
          w_next_state = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (w_tgt_rsp || w_timeout) begin
          w_next_state = ST_RESP;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, latched request, timeout counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_sel       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= 4'd0;
      r_a_valid   <= 1'b0;
      r_b_valid   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_a_valid   <= (w_next_state == ST_ISSUE) && !w_next_sel;
      r_b_valid   <= (w_next_state == ST_ISSUE) &&  w_next_sel;
      r_rsp_valid <= (w_next_state == ST_RESP);
      case (r_state)
        ST_IDLE: begin
          r_cnt <= 4'd0;
          if (bus.req_valid) begin
            r_we    <= bus.req_we;
            r_sel   <= w_req_sel;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            if (is_misaligned(bus.req_addr[1:0])) begin
              r_rsp_rdata <= '0;
              r_rsp_err   <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_timeout) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_tgt_rsp) begin
            r_rsp_rdata <= r_we ? '0 : w_mux_rdata;
            r_rsp_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
          end
        end
        ST_RESP: begin
          r_cnt <= 4'd0;
        end
        default: begin
          r_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Ready is held low throughout reset and rises on the first idle cycle after release.
  assign bus.req_ready = rst_n && (r_state == ST_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.a_valid   = r_a_valid;
  assign bus.b_valid   = r_b_valid;
  assign bus.a_we      = r_we;
  assign bus.b_we      = r_we;
  assign bus.a_addr    = r_addr;
  assign bus.b_addr    = r_addr;
  assign bus.a_wdata   = r_wdata;
  assign bus.b_wdata   = r_wdata;

endmodule

// File: doc/bus_demux_2.md
# bus_demux_2

Single-outstanding request router between the multicycle core's memory port and two downstream responders: data memory on port A, MMIO on port B. Each request is steered to one target by address. The selected target's response is returned upstream. Alignment and timeout errors are flagged. It is the write/issue-side counterpart to the 32-bit 2:1 read-data selector, which it instantiates for response selection.

## Interface
Parameters:
- DATA_W, 32, data and address width
- SPLIT_ADDR, 32'hFFFF_0000, addresses >= SPLIT_ADDR go to port B; all others go to port A
- TIMEOUT, 15, maximum cycles spent in ISSUE+WAIT before an error response (1..15)

Ports:
- clk  in  1  single clock, all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  upstream request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  DATA_W  byte address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  misaligned address or timeout
- a_valid, b_valid  out  1  downstream request strobe
- a_ready, b_ready  in  1  downstream accepts the request
- a_we, b_we  out  1  latched req_we
- a_addr, b_addr  out  DATA_W  latched address
- a_wdata, b_wdata  out  DATA_W  latched write data
- a_rsp_valid, b_rsp_valid  in  1  downstream completion
- a_rdata, b_rdata  in  DATA_W  downstream read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - req_ready=1.
  - On req_valid, latch we, addr, wdata and sel = (req_addr >= SPLIT_ADDR).
  - If req_addr[1:0] != 0, go to RESP with err=1 and issue nothing downstream.
  - Otherwise go to ISSUE.
- ISSUE
  - Assert the selected target's valid only. Hold all fields stable until that target's ready is sampled high.
  - On ready, go to WAIT.
- WAIT
  - On the selected target's rsp_valid, capture rdata through mux_2 (sel chooses a_rdata or b_rdata). Capture 0 if the request is a write. Go to RESP with err=0.
- RESP
  - rsp_valid=1 for exactly one cycle, then go to IDLE.
- The non-selected target's rsp_valid is ignored in every state. Any rsp_valid seen in IDLE or ISSUE is ignored.
- Timeout counter (4-bit)
  - Cleared on entering ISSUE; increments each ISSUE/WAIT cycle.
  - When it equals TIMEOUT-1 and the transaction has not completed that cycle, go to RESP with err=1 and rdata=0.
  - Completion in the same cycle wins over timeout.
- Non-selected a_*/b_* outputs: valid=0. we, addr and wdata are driven with the latched values to both ports; only valid qualifies them.

## Timing
- Reset values while rst_n=0 and on the first cycle after release:
  - State IDLE; all valids 0; rsp_err 0; rsp_rdata 0; latched fields 0; counter 0.
  - req_ready=0 while rst_n=0 and 1 in IDLE afterwards.
- Reset mid-transaction drops the transaction. Downstream valid deasserts the cycle after the reset edge, and no upstream response is produced.
- Minimum latency, with request accepted at cycle 0:
  - x_valid is high at cycle 1.
  - If ready is high at cycle 1 and x_rsp_valid is high at cycle 2, rsp_valid is high at cycle 3.
- Misaligned request accepted at cycle 0 gives rsp_valid/rsp_err at cycle 1.
- Timeout with the target never ready gives rsp_valid/rsp_err at cycle TIMEOUT+1.
- Back-to-back: req_ready is reasserted at cycle 4 of the minimum case, so the steady-state period is 4 cycles.
- rsp_rdata and rsp_err are registered and valid only while rsp_valid=1; they hold their values otherwise.

## Structure
- bus_pkg
  - State enum typedef (IDLE, ISSUE, WAIT, RESP).
  - DATA_W and SPLIT_ADDR defaults.
  - TIMEOUT default.
- Sub-module: mux_2 instance selecting a_rdata/b_rdata by the latched sel.
- Everything else is a single always_ff FSM with a next-state always_comb.

## Test plan
- Write 0x0000_1000 with data 0x1234_5678, a_ready=1 at cycle 1, a_rsp_valid at cycle 2 -> a_valid high for one cycle with the correct addr/data, b_valid never high, rsp_valid at cycle 3, rsp_err=0, rsp_rdata=0.
- Read 0xFFFF_0004, b_ready delayed to cycle 3, b_rsp_valid at cycle 5 with b_rdata=0xDEAD_BEEF -> b_valid high for cycles 1-3, rsp_valid at cycle 6 with rdata 0xDEAD_BEEF.
- Read 0x0000_1002 -> no downstream valid, rsp_valid and rsp_err at cycle 1, rdata 0.
- Read 0x0000_2000 with a_ready stuck at 0, TIMEOUT=15 -> a_valid high for cycles 1-15, rsp_err at cycle 16, then req_ready=1.
- Read from A while b_rsp_valid pulses with b_rdata=0xFFFF_FFFF during WAIT, then a_rsp_valid with 0x0000_00AA -> rsp_rdata=0x0000_00AA.
- Assert rst_n=0 during WAIT -> no rsp_valid, a_valid=0 and req_ready=0 during reset, req_ready=1 on the first cycle after release.
